// File: rtl/ro_trace_pkg.sv
// Shared types and helpers for the ring-oscillator trace capture engine.
package ro_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_READOUT
  } trace_state_t;

  // Width needed to hold a sample count in the range 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ro_trace_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, 1-cycle read latency.
module ro_trace_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; resetting it would block RAM-macro inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ro_trace_capture.sv
// Triggered trace capture of the add-tree sum stream with valid/ready readout.
// Optional feature: define TRACE_DECIM_EN to add the `decim` sample-decimation port.
module ro_trace_capture
  import ro_trace_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          arm,
  input  logic                          abort,
  input  logic                          trigger,
  input  logic [WIDTH-1:0]              sample_in,
  input  logic                          valid_in,
`ifdef TRACE_DECIM_EN
  input  logic [3:0]                    decim,
`endif
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          rd_last,
  output logic                          busy,
  output logic                          done,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  trace_state_t   state, state_nx;
  logic [AW-1:0]  rd_ptr, raddr;
  logic           rd_prime;
  logic [WIDTH-1:0] ram_q;
  logic           accept, cap_phase, keep, wr_en, full_nx, xfer;

  assign accept    = valid_in && en;
  assign cap_phase = (state == ST_ARMED && trigger) || state == ST_CAPTURE;

`ifdef TRACE_DECIM_EN
  logic [3:0] decim_q, decim_cnt;
  assign keep = (decim_cnt == 4'd0);
`else
  assign keep = 1'b1;
`endif

  assign wr_en   = cap_phase && accept && keep && (count < CW'(DEPTH)) && !abort;
  assign full_nx = wr_en && (count == CW'(DEPTH - 1));
  assign xfer    = rd_valid && rd_ready;

  // Look one address ahead on a transfer so the next sample is ready after a single idle cycle.
  assign raddr = xfer ? rd_ptr + AW'(1) : rd_ptr;

  ro_trace_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count[AW-1:0]),
    .wdata (sample_in),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (arm)              state_nx = ST_ARMED;
      ST_ARMED:   if (trigger)          state_nx = ST_CAPTURE;
      ST_CAPTURE: if (full_nx)          state_nx = ST_READOUT;
      ST_READOUT: if (xfer && rd_last)  state_nx = ST_IDLE;
      default:                          state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_ptr   <= '0;
      rd_prime <= 1'b0;
`ifdef TRACE_DECIM_EN
      decim_q   <= '0;
      decim_cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      busy  <= (state_nx != ST_IDLE);
      done  <= (state_nx == ST_READOUT);
      if (abort) begin
        count    <= '0;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
        rd_prime <= 1'b0;
      end else begin
        if (state == ST_IDLE && arm) begin
          count    <= '0;
          rd_ptr   <= '0;
          rd_prime <= 1'b0;
`ifdef TRACE_DECIM_EN
          decim_q   <= decim;
          decim_cnt <= '0;
`endif
        end
        if (wr_en) count <= count + CW'(1);
`ifdef TRACE_DECIM_EN
        if (cap_phase && accept && count < CW'(DEPTH))
          decim_cnt <= (decim_cnt == decim_q) ? 4'd0 : decim_cnt + 4'd1;
`endif
        // rd_prime marks that ram_q already holds the sample at rd_ptr.
        if (state == ST_READOUT) begin
          if (xfer) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_ptr   <= rd_ptr + AW'(1);
            rd_prime <= !rd_last;
          end else if (!rd_valid && rd_prime) begin
            rd_data  <= ram_q;
            rd_valid <= 1'b1;
            rd_last  <= (rd_ptr == AW'(DEPTH - 1));
            rd_prime <= 1'b0;
          end else if (!rd_valid) begin
            rd_prime <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ro_trace_capture.sv
// Scoreboard bench for ro_trace_capture (WIDTH=9, DEPTH=8); decimation scenario runs when TRACE_DECIM_EN is defined.
module tb_ro_trace_capture;

  localparam int WIDTH = 9;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst, en, arm, abort, trigger, valid_in, rd_ready;
  logic [WIDTH-1:0] sample_in;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, rd_last, busy, done;
  logic [3:0]       count;
`ifdef TRACE_DECIM_EN
  logic [3:0]       decim;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q[$];
  int mdl_cnt, mdl_dcnt, mdl_decim;
  bit mdl_cap;

  ro_trace_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .arm       (arm),
    .abort     (abort),
    .trigger   (trigger),
    .sample_in (sample_in),
    .valid_in  (valid_in),
`ifdef TRACE_DECIM_EN
    .decim     (decim),
`endif
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int dec);
    arm = 1'b1;
`ifdef TRACE_DECIM_EN
    decim     = dec[3:0];
    mdl_decim = dec;
`else
    mdl_decim = 0;
`endif
    mdl_cnt  = 0;
    mdl_dcnt = 0;
    mdl_cap  = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  // Drives one valid sample; the bench model pushes what should land in the window.
  task automatic feed(input logic [WIDTH-1:0] v, input logic e, input logic trig);
    sample_in = v;
    valid_in  = 1'b1;
    en        = e;
    trigger   = trig;
    if (trig) mdl_cap = 1'b1;
    if (mdl_cap && e && mdl_cnt < DEPTH) begin
      if (mdl_dcnt == 0) begin
        exp_q.push_back(v);
        mdl_cnt++;
      end
      mdl_dcnt = (mdl_dcnt == mdl_decim) ? 0 : mdl_dcnt + 1;
    end
    tick();
    valid_in = 1'b0;
    en       = 1'b1;
    trigger  = 1'b0;
  endtask

  task automatic read_window(input string name, input int stall_idx);
    int idx = 0;
    int budget = 0;
    logic [WIDTH-1:0] e;
    rd_ready = 1'b1;
    while (idx < DEPTH && budget < 200) begin
      budget++;
      if (rd_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (rd_data !== e)
          begin bad++; $display("FAIL %s data[%0d]: got %h want %h", name, idx, rd_data, e); end
        total++;
        if (rd_last !== (idx == DEPTH - 1))
          begin bad++; $display("FAIL %s last[%0d]: got %b want %b", name, idx, rd_last, idx == DEPTH - 1); end
        if (idx == stall_idx) begin
          rd_ready = 1'b0;
          for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (rd_valid !== 1'b1 || rd_data !== e)
              begin bad++; $display("FAIL %s stall[%0d]: got v=%b d=%h want v=1 d=%h", name, k, rd_valid, rd_data, e); end
          end
          rd_ready = 1'b1;
        end
        tick();
        idx++;
        total++;
        if (rd_valid !== 1'b0)
          begin bad++; $display("FAIL %s gap[%0d]: rd_valid got %b want 0", name, idx, rd_valid); end
      end else begin
        tick();
      end
    end
    total++;
    if (idx < DEPTH)
      begin bad++; $display("FAIL %s timeout: got %0d reads want %0d", name, idx, DEPTH); end
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL %s end_state: busy=%b done=%b want 0 0", name, busy, done); end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    valid_in = 1'b0; rd_ready = 1'b0; sample_in = '0;
`ifdef TRACE_DECIM_EN
    decim = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({rd_data, rd_valid, rd_last, busy, done, count} !== '0)
      begin bad++; $display("FAIL reset: got d=%h v=%b l=%b b=%b dn=%b c=%0d want all 0",
                           rd_data, rd_valid, rd_last, busy, done, count); end
  endtask

  task automatic check_full(input string name);
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || count !== 4'd8)
      begin bad++; $display("FAIL %s full: got done=%b busy=%b count=%0d want 1 1 8", name, done, busy, count); end
  endtask

  task automatic test_basic;
    do_arm(0);
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      begin bad++; $display("FAIL basic armed: busy=%b done=%b want 1 0", busy, done); end
    for (int i = 1; i <= 8; i++) feed(WIDTH'(i), 1'b1, i == 1);
    check_full("basic");
    read_window("basic", -1);
  endtask

  task automatic test_gaps;
    do_arm(0);
    for (int i = 1; i <= 10; i++) feed(WIDTH'(i), !(i == 3 || i == 4), i == 1);
    check_full("gaps");
    read_window("gaps", -1);
  endtask

  task automatic test_back_to_back;
    do_arm(0);
    for (int i = 1; i <= 8; i++) feed(WIDTH'(i), 1'b1, i == 1);
    read_window("backpressure", 2);
  endtask

  task automatic test_abort;
    do_arm(0);
    for (int i = 1; i <= 4; i++) feed(WIDTH'(i), 1'b1, i == 1);
    total++;
    if (count !== 4'd4)
      begin bad++; $display("FAIL abort pre: count got %0d want 4", count); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || count !== 4'd0 || rd_valid !== 1'b0)
      begin bad++; $display("FAIL abort: busy=%b count=%0d rd_valid=%b want 0 0 0", busy, count, rd_valid); end
    exp_q.delete();
    do_arm(0);
    for (int i = 0; i < 8; i++) feed(WIDTH'(9'h100 + i), 1'b1, i == 0);
    check_full("abort");
    read_window("abort", -1);
  endtask

  task automatic test_pretrigger;
    do_arm(0);
    for (int i = 0; i < 3; i++) feed(WIDTH'(9'h055 + i), 1'b1, 1'b0);
    total++;
    if (count !== 4'd0 || busy !== 1'b1 || done !== 1'b0)
      begin bad++; $display("FAIL pretrig: count=%0d busy=%b done=%b want 0 1 0", count, busy, done); end
    feed(9'h1FF, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) feed(WIDTH'(9'h020 + i), 1'b1, 1'b0);
    check_full("pretrig");
    read_window("pretrig", -1);
  endtask

`ifdef TRACE_DECIM_EN
  task automatic test_decim;
    do_arm(1);
    for (int i = 1; i <= 16; i++) feed(WIDTH'(i), 1'b1, i == 1);
    read_window("decim", -1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_abort();
    test_pretrigger();
`ifdef TRACE_DECIM_EN
    test_decim();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
